// File: rtl/tmds_decoder.sv
// TMDS channel decoder: recovers 10-bit symbol alignment from an arbitrarily
// slipped deserializer stream by hunting for control tokens, then decodes each
// aligned symbol into control bits or a pixel byte.
module tmds_decoder #(
    parameter int unsigned LOCK_COUNT     = 16,
    parameter int unsigned SEARCH_TIMEOUT = 1024,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [9:0] i_data,
    output logic       o_de,
    output logic [1:0] o_ctrl,
    output logic [7:0] o_data,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int unsigned LCW = (LOCK_COUNT     > 1) ? $clog2(LOCK_COUNT)     : 1;
    localparam int unsigned TCW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int unsigned OCW = (LOSS_TIMEOUT   > 1) ? $clog2(LOSS_TIMEOUT)   : 1;

    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_COUNT - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(SEARCH_TIMEOUT - 1);
    localparam logic [OCW-1:0] LOSS_LAST = OCW'(LOSS_TIMEOUT - 1);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic {
        ST_SEARCH,
        ST_LOCKED
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [3:0]     offset;
    logic [3:0]     offset_nx;
    logic [3:0]     offset_inc;
    logic [LCW-1:0] ctrl_cnt;
    logic [LCW-1:0] ctrl_cnt_nx;
    logic [TCW-1:0] tmo_cnt;
    logic [TCW-1:0] tmo_cnt_nx;
    logic [OCW-1:0] loss_cnt;
    logic [OCW-1:0] loss_cnt_nx;

    logic [9:0]     cur;
    logic [9:0]     prev;
    logic [19:0]    pair;
    logic [9:0]     win;

    logic           is_tok;
    logic [1:0]     tok_ctrl;
    logic [7:0]     d;
    logic [7:0]     dec;

    // Two-word history so any 10-bit window spanning a word boundary is available
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cur  <= '0;
            prev <= '0;
        end else begin
            cur  <= i_data;
            prev <= cur;
        end
    end

    // prev holds the earlier word, so it occupies the low half of the pair
    always_comb begin
        pair = {cur, prev};
    end

    // Extract the symbol at the current bit-slip offset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            win <= '0;
        end else begin
            win <= pair[offset +: 10];
        end
    end

    // Control token recognition on the aligned window
    always_comb begin
        is_tok   = 1'b0;
        tok_ctrl = 2'b00;
        case (win)
            TOK_00: begin is_tok = 1'b1; tok_ctrl = 2'b00; end
            TOK_01: begin is_tok = 1'b1; tok_ctrl = 2'b01; end
            TOK_10: begin is_tok = 1'b1; tok_ctrl = 2'b10; end
            TOK_11: begin is_tok = 1'b1; tok_ctrl = 2'b11; end
            default: begin is_tok = 1'b0; tok_ctrl = 2'b00; end
        endcase
    end

    // Undo DC-balance inversion, then undo the XOR/XNOR transition chain
    always_comb begin
        d      = win[9] ? ~win[7:0] : win[7:0];
        dec    = '0;
        dec[0] = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            dec[i] = win[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    // Offset advance with 9 -> 0 wrap
    always_comb begin
        offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    end

    // Alignment state and counters
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_SEARCH;
            offset   <= '0;
            ctrl_cnt <= '0;
            tmo_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nx;
            offset   <= offset_nx;
            ctrl_cnt <= ctrl_cnt_nx;
            tmo_cnt  <= tmo_cnt_nx;
            loss_cnt <= loss_cnt_nx;
        end
    end

    // Lock search / loss detection; a lock on the same cycle as a timeout wins
    always_comb begin
        state_nx    = state;
        offset_nx   = offset;
        ctrl_cnt_nx = ctrl_cnt;
        tmo_cnt_nx  = tmo_cnt;
        loss_cnt_nx = loss_cnt;
        case (state)
            ST_SEARCH: begin
                if (is_tok && (ctrl_cnt == LOCK_LAST)) begin
                    state_nx    = ST_LOCKED;
                    ctrl_cnt_nx = '0;
                    tmo_cnt_nx  = '0;
                    loss_cnt_nx = '0;
                end else begin
                    ctrl_cnt_nx = is_tok ? ctrl_cnt + 1'b1 : '0;
                    if (tmo_cnt == TMO_LAST) begin
                        offset_nx   = offset_inc;
                        ctrl_cnt_nx = '0;
                        tmo_cnt_nx  = '0;
                    end else begin
                        tmo_cnt_nx = tmo_cnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (is_tok) begin
                    loss_cnt_nx = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_nx    = ST_SEARCH;
                    offset_nx   = offset_inc;
                    ctrl_cnt_nx = '0;
                    tmo_cnt_nx  = '0;
                    loss_cnt_nx = '0;
                end else begin
                    loss_cnt_nx = loss_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_SEARCH;
            end
        endcase
    end

    // Registered decode; outputs are held at zero until alignment is locked
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_de   <= 1'b0;
            o_ctrl <= '0;
            o_data <= '0;
        end else if (state != ST_LOCKED) begin
            o_de   <= 1'b0;
            o_ctrl <= '0;
            o_data <= '0;
        end else if (is_tok) begin
            o_de   <= 1'b0;
            o_ctrl <= tok_ctrl;
        end else begin
            o_de   <= 1'b1;
            o_data <= dec;
        end
    end

    // Status outputs come straight from the alignment registers
    always_comb begin
        o_locked = (state == ST_LOCKED);
        o_offset = offset;
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: each driven word pushes the expected
// output seen four edges later; a monitor pops and compares on falling edges.
module tb_tmds_decoder;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic [9:0] din  = '0;
    logic       o_de;
    logic [1:0] o_ctrl;
    logic [7:0] o_data;
    logic       o_locked;
    logic [3:0] o_offset;

    tmds_decoder #(
        .LOCK_COUNT     (16),
        .SEARCH_TIMEOUT (64),
        .LOSS_TIMEOUT   (4096)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_data   (din),
        .o_de     (o_de),
        .o_ctrl   (o_ctrl),
        .o_data   (o_data),
        .o_locked (o_locked),
        .o_offset (o_offset)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        bit          chk;
        logic [15:0] exp;
    } ent_t;

    ent_t        sb[$];
    ent_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned rel     = 0;
    logic        last_rstn;
    logic [15:0] act;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;

    // {locked, offset, de, ctrl, data}
    function automatic logic [15:0] pk(input logic l, input int unsigned off,
                                       input logic de, input logic [1:0] c,
                                       input logic [7:0] dt);
        logic [3:0] o4;
        o4 = off[3:0];
        return {l, o4, de, c, dt};
    endfunction

    task automatic step(input logic [9:0] w, input bit chk, input logic [15:0] e);
        ent_t x;
        din   = w;
        x.cyc = cyc;
        x.chk = chk;
        x.exp = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sb.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
        rel  = cyc;
    endtask

    // Monitor: async-reset check on reset fall, scoreboard pop on clock fall
    initial begin
        last_rstn = 1'b1;
        forever begin
            @(negedge clk or negedge rstn);
            if (!rstn && last_rstn) begin
                #1;
                act = {o_locked, o_offset, o_de, o_ctrl, o_data};
                n_tests++;
                if (act != 16'h0000) begin
                    n_fail++;
                    $display("FAIL async_reset t=%0t got locked=%b offset=%0d de=%b ctrl=%b data=%h, expected all zero",
                             $time, act[15], act[14:11], act[10], act[9:8], act[7:0]);
                end
            end else begin
                while (sb.size() != 0 && (sb[0].cyc + 4) <= cyc) begin
                    mon_e = sb.pop_front();
                    act   = {o_locked, o_offset, o_de, o_ctrl, o_data};
                    if ((mon_e.cyc + 4) != cyc) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_align got cyc=%0d expected cyc=%0d", cyc, mon_e.cyc + 4);
                    end else if (mon_e.chk) begin
                        n_tests++;
                        if (act != mon_e.exp) begin
                            n_fail++;
                            $display("FAIL out cyc=%0d got locked=%b offset=%0d de=%b ctrl=%b data=%h, expected locked=%b offset=%0d de=%b ctrl=%b data=%h",
                                     cyc, act[15], act[14:11], act[10], act[9:8], act[7:0],
                                     mon_e.exp[15], mon_e.exp[14:11], mon_e.exp[10], mon_e.exp[9:8], mon_e.exp[7:0]);
                        end
                    end
                end
            end
            last_rstn = rstn;
        end
    end

    logic [9:0] t4_w [8]  = '{10'h3C3, 10'h354, 10'h0F0, 10'h154, 10'h2A5, 10'h2AB, 10'h155, 10'h0AB};
    logic       t4_de[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] t4_c [8]  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
    logic [7:0] t4_d [8]  = '{8'h44, 8'h44, 8'hEE, 8'hEE, 8'h10, 8'h10, 8'hFF, 8'hFF};

    initial begin
        // reset with random input, then random input unlocked
        #2 rstn = 1'b0;
        @(posedge clk);
        #1;
        for (int j = 0; j < 6; j++) step(10'($urandom_range(0, 1023)), 1'b1, pk(0, 0, 0, 2'b00, 8'h00));
        rstn = 1'b1;
        rel  = cyc;
        for (int j = 0; j < 40; j++) step(10'($urandom_range(0, 1023)), 1'b1, pk(0, 0, 0, 2'b00, 8'h00));

        // aligned lock at offset 0 and first decodes
        do_reset();
        for (int j = 0; j < 15; j++) step(TOK_00, 1'b1, pk(0, 0, 0, 2'b00, 8'h00));
        step(TOK_00,  1'b1, pk(1, 0, 0, 2'b00, 8'h00));
        step(10'h100, 1'b1, pk(1, 0, 1, 2'b00, 8'h00));
        step(10'h200, 1'b1, pk(1, 0, 1, 2'b00, 8'hFF));
        step(TOK_01,  1'b1, pk(1, 0, 0, 2'b01, 8'hFF));

        // all four tokens and assorted data words
        for (int j = 0; j < 8; j++) step(t4_w[j], 1'b1, pk(1, 0, t4_de[j], t4_c[j], t4_d[j]));

        // loss timeout restarted by one token, then exact 4096-word loss
        for (int j = 0; j < 3999; j++) step(10'h100, 1'b1, pk(1, 0, 1, 2'b01, 8'h00));
        step(TOK_01, 1'b1, pk(1, 0, 0, 2'b01, 8'h00));
        for (int j = 0; j < 4095; j++) step(10'h100, 1'b1, pk(1, 0, 1, 2'b01, 8'h00));
        step(10'h100, 1'b1, pk(0, 1, 1, 2'b01, 8'h00));
        for (int j = 0; j < 3; j++) step(10'h100, 1'b1, pk(0, 1, 0, 2'b00, 8'h00));

        // stream shifted by 3 bits: slips every 64 symbols, locks at offset 3
        do_reset();
        for (int j = 0; j < 236; j++) begin
            int unsigned n;
            int unsigned off;
            n   = j + 4;
            off = (n / 64 > 3) ? 3 : n / 64;
            step(10'h15D, 1'b1, pk(n >= 209, off, 0, (n >= 210) ? 2'b11 : 2'b00, 8'h00));
        end

        // lock at offset 9, forced loss wraps offset to 0
        do_reset();
        for (int j = 0; j < 619; j++) begin
            int unsigned n;
            int unsigned off;
            n   = j + 4;
            off = (n / 64 > 9) ? 9 : n / 64;
            step(10'h1AA, 1'b1, pk(n >= 593, off, 0, 2'b00, 8'h00));
        end
        step(10'h1AA, 1'b1, pk(1, 9, 1, 2'b00, 8'hFF));
        for (int j = 0; j < 4094; j++) step(10'h100, 1'b1, pk(1, 9, 1, 2'b00, 8'hFF));
        step(10'h100, 1'b1, pk(0, 0, 1, 2'b00, 8'hFF));
        for (int j = 0; j < 3; j++) step(10'h100, 1'b1, pk(0, 0, 0, 2'b00, 8'h00));

        // reset in the middle of a data burst; relock is needed afterwards
        do_reset();
        for (int j = 0; j < 15; j++) step(TOK_00, 1'b1, pk(0, 0, 0, 2'b00, 8'h00));
        step(TOK_00, 1'b1, pk(1, 0, 0, 2'b00, 8'h00));
        for (int j = 0; j < 6; j++) step(10'h3C3, 1'b1, pk(1, 0, 1, 2'b00, 8'h44));
        din = 10'h3C3;
        #2;
        rstn = 1'b0;
        sb.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b1;
        rel  = cyc;
        for (int j = 0; j < 30; j++) step(10'h3C3, 1'b1, pk(0, 0, 0, 2'b00, 8'h00));

        repeat (6) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
